// File: rtl/mips_cpu_pkg.sv
// Shared types for the register-file writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One pending register-file write: destination register and its value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/mips_cpu_wb_fifo.sv
// In-order circular buffer of pending writes, up to two pushes and one pop per cycle.
// Latency: an entry pushed at edge k is visible at the head/entry array from cycle k+1.
// Backpressure: none internally; the caller must only push into free slots.
//
// Ports: clk, reset (sync, active-high); i_push0/i_ent0 first (older) push,
// i_push1/i_ent1 second push (only valid together with i_push0); i_pop removes
// the head; o_entries raw storage, o_head head index, o_count occupancy.
module mips_cpu_wb_fifo
    import mips_cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push0,
    input  wb_entry_t     i_ent0,
    input  logic          i_push1,
    input  wb_entry_t     i_ent1,
    input  logic          i_pop,
    output wb_entry_t     o_entries [DEPTH],
    output logic [PW-1:0] o_head,
    output logic [CW-1:0] o_count
);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    logic [PW-1:0] w_tail_p1;
    assign w_tail_p1 = r_tail + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push0) begin
                r_mem[r_tail] <= i_ent0;
            end
            if (i_push0 && i_push1) begin
                r_mem[w_tail_p1] <= i_ent1;
            end
            r_tail  <= r_tail + PW'(i_push0) + PW'(i_push0 && i_push1);
            r_head  <= r_head + PW'(i_pop);
            r_count <= r_count + CW'(i_push0) + CW'(i_push0 && i_push1) - CW'(i_pop);
        end
    end

    assign o_entries = r_mem;
    assign o_head    = r_head;
    assign o_count   = r_count;

endmodule

// File: rtl/mips_cpu_reg_writeback.sv
// Sole driver of the register-file write port: buffers ALU and load results, commits one per cycle.
// Latency: request sampled at edge k is written at edge k+1 at the earliest; no bypass to the port.
// Backpressure: stall when fewer than two slots are free; requests that still find no slot are dropped and flag overflow.
//
// Ports: clk/reset (sync, active-high); ld_* and alu_* result requests;
// fwd_reg -> fwd_hit/fwd_data lookup over buffered writes; stall, overflow,
// pending_count status; write_enable/write_reg/write_data register-file port.
// Optional trace output: define MIPS_CPU_WB_TRACE_EN.
module mips_cpu_reg_writeback
    import mips_cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_dest,
    input  logic [31:0]             ld_data,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_dest,
    input  logic [31:0]             alu_data,
    input  logic [4:0]              fwd_reg,
    output logic                    fwd_hit,
    output logic [31:0]             fwd_data,
    output logic                    stall,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  pending_count,
    output logic                    write_enable,
    output logic [4:0]              write_reg,
    output logic [31:0]             write_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     w_entries [DEPTH];
    logic [PW-1:0] w_head;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic [CW:0]   w_free;
    logic          w_ld_req, w_alu_req;
    logic          w_ld_acc, w_alu_acc;
    logic          w_push0, w_push1;
    wb_entry_t     w_ent0, w_ent1;
    logic          r_overflow;

    // Zero-register writes are architectural no-ops; filter them before anything else sees them.
    assign w_ld_req  = ld_valid  && (ld_dest  != REG_ZERO);
    assign w_alu_req = alu_valid && (alu_dest != REG_ZERO);

    // The head commits unconditionally whenever it exists; reset suppresses the commit.
    assign w_pop = (w_count != '0) && !reset;

    // Free slots counting the slot released by this cycle's commit.
    assign w_free = (CW+1)'(DEPTH) - (CW+1)'(w_count) + (CW+1)'(w_pop);

    // Load belongs to the older instruction, so it claims the first free slot.
    assign w_ld_acc  = w_ld_req  && (w_free >= (CW+1)'(1));
    assign w_alu_acc = w_alu_req && (w_free >= (w_ld_acc ? (CW+1)'(2) : (CW+1)'(1)));

    // Compact accepted requests so push0 is always the older one.
    assign w_push0 = w_ld_acc || w_alu_acc;
    assign w_push1 = w_ld_acc && w_alu_acc;
    assign w_ent0  = w_ld_acc ? wb_entry_t'{dest: ld_dest, data: ld_data}
                              : wb_entry_t'{dest: alu_dest, data: alu_data};
    assign w_ent1  = wb_entry_t'{dest: alu_dest, data: alu_data};

    mips_cpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push0   (w_push0),
        .i_ent0    (w_ent0),
        .i_push1   (w_push1),
        .i_ent1    (w_ent1),
        .i_pop     (w_pop),
        .o_entries (w_entries),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if ((w_ld_req && !w_ld_acc) || (w_alu_req && !w_alu_acc)) begin
            r_overflow <= 1'b1;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    logic [PW-1:0] w_idx;
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = w_head + PW'(i);
            if ((CW'(i) < w_count) && (fwd_reg != REG_ZERO) &&
                (w_entries[w_idx].dest == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_entries[w_idx].data;
            end
        end
    end

    assign stall         = (CW'(DEPTH) - w_count) < CW'(2);
    assign overflow      = r_overflow;
    assign pending_count = w_count;
    assign write_enable  = w_pop;
    assign write_reg     = w_entries[w_head].dest;
    assign write_data    = w_entries[w_head].data;

`ifdef MIPS_CPU_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (write_enable) begin
                $display("WB r%0d <= %0d", write_reg, write_data);
            end
            if (w_ld_req && !w_ld_acc) begin
                $display("ERROR wb overflow: dropped ld dest %0d", ld_dest);
            end
            if (w_alu_req && !w_alu_acc) begin
                $display("ERROR wb overflow: dropped alu dest %0d", alu_dest);
            end
        end
    end
`else
    // Trace disabled: no display logic.
`endif

endmodule

// File: tb/tb_mips_cpu_reg_writeback.sv
// Self-checking bench for mips_cpu_reg_writeback against a queue-based model.
// Latency: checks every cycle at negedge+1 against the model state.
// Backpressure: stimulus sometimes honours stall and sometimes ignores it to provoke drops.
module tb_mips_cpu_reg_writeback;
    import mips_cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, alu_valid;
    logic [4:0]  ld_dest, alu_dest, fwd_reg;
    logic [31:0] ld_data, alu_data;
    logic        fwd_hit, stall, overflow, write_enable;
    logic [31:0] fwd_data, write_data;
    logic [4:0]  write_reg;
    logic [$clog2(DEPTH):0] pending_count;

    always #5 clk = ~clk;

    mips_cpu_reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .alu_valid     (alu_valid),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .fwd_reg       (fwd_reg),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .stall         (stall),
        .overflow      (overflow),
        .pending_count (pending_count),
        .write_enable  (write_enable),
        .write_reg     (write_reg),
        .write_data    (write_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending writes as a plain queue, a sticky error bit, register files.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ment_t;
    ment_t       mq[$];
    bit          m_ovf;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];

    task automatic model_push(input logic v, input logic [4:0] r, input logic [31:0] d);
        ment_t e;
        if (v && r != 5'd0) begin
            if (mq.size() < DEPTH) begin
                e.r = r;
                e.d = d;
                mq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst,
                        input logic lv, input logic [4:0] ldd, input logic [31:0] ldt,
                        input logic av, input logic [4:0] ad, input logic [31:0] adt,
                        input logic [4:0] fr);
        logic        e_hit;
        logic [31:0] e_fwd;
        logic        e_we;
        @(negedge clk);
        reset = rst; ld_valid = lv; ld_dest = ldd; ld_data = ldt;
        alu_valid = av; alu_dest = ad; alu_data = adt; fwd_reg = fr;
        #1;
        e_we = !rst && (mq.size() != 0);
        check_val("write_enable", 32'(write_enable), 32'(e_we));
        if (e_we) begin
            check_val("write_reg", 32'(write_reg), 32'(mq[0].r));
            check_val("write_data", write_data, mq[0].d);
        end
        if (write_enable) dut_rf[write_reg] = write_data;
        check_val("pending_count", 32'(pending_count), 32'(mq.size()));
        check_val("stall", 32'(stall), 32'((DEPTH - mq.size()) < 2));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        e_hit = 1'b0;
        e_fwd = '0;
        foreach (mq[i]) begin
            if (fr != 5'd0 && mq[i].r == fr) begin
                e_hit = 1'b1;
                e_fwd = mq[i].d;
            end
        end
        check_val("fwd_hit", 32'(fwd_hit), 32'(e_hit));
        check_val("fwd_data", fwd_data, e_fwd);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (mq.size() != 0) begin
                model_rf[mq[0].r] = mq[0].d;
                void'(mq.pop_front());
            end
            model_push(lv, ldd, ldt);
            model_push(av, ad, adt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        m_ovf = 1'b0;
        reset = 1'b1; ld_valid = 1'b0; alu_valid = 1'b0;
        ld_dest = '0; alu_dest = '0; ld_data = '0; alu_data = '0; fwd_reg = '0;
        repeat (2) @(posedge clk);

        // Reset state and single write.
        idle(1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1234, 5'd0);
        idle(2);
        check_val("single_rf8", dut_rf[8], 32'h1234);

        // Dual push to the same register: ld first, alu youngest.
        step(1'b0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 5'd0);
        #1; fwd_reg = 5'd3; #1;
        check_val("dual_fwd_hit", 32'(fwd_hit), 32'd1);
        check_val("dual_fwd_data", fwd_data, 32'hBBBB);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3);
        idle(2);
        check_val("dual_rf3", dut_rf[3], 32'hBBBB);

        // Zero destination is ignored.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0);
        #1;
        check_val("zero_count", 32'(pending_count), 32'd0);
        idle(1);

        // Fill until stall, then overflow on the alu half of a dual push.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 5'(10 + 2*i), 32'(1000 + i), 1'b1, 5'(11 + 2*i), 32'(2000 + i), 5'd0);
        #1;
        check_val("fill_overflow", 32'(overflow), 32'd1);
        check_val("fill_stall", 32'(stall), 32'd1);
        idle(6);
        check_val("overflow_sticky", 32'(overflow), 32'd1);
        check_val("drop_alu_rf17", dut_rf[17], 32'd0);

        // Wrap-around with ten sequential single pushes.
        for (int i = 1; i <= 10; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(100 + i), 5'(i));
        idle(2);
        for (int i = 1; i <= 10; i++) check_val("wrap_rf", dut_rf[i], 32'(100 + i));

        // Reset with three writes pending.
        step(1'b0, 1'b1, 5'd20, 32'h5, 1'b1, 5'd21, 32'h6, 5'd0);
        step(1'b0, 1'b1, 5'd22, 32'h7, 1'b1, 5'd23, 32'h8, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(2);
        check_val("rst_rf22", dut_rf[22], 32'd0);

        // Random traffic with occasional resets and disregard for stall.
        for (int n = 0; n < 600; n++) begin
            logic lv, av, rst;
            rst = ($urandom_range(0, 59) == 0);
            lv  = ($urandom_range(0, 2) != 0);
            av  = ($urandom_range(0, 2) != 0);
            if ((DEPTH - mq.size()) < 2 && $urandom_range(0, 3) != 0) begin
                lv = 1'b0;
                av = 1'b0;
            end
            step(rst, lv, 5'($urandom_range(0, 7)), $urandom,
                 av, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
        end
        idle(DEPTH + 1);
        for (int i = 0; i < 32; i++) check_val("final_rf", dut_rf[i], model_rf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_reg_writeback.md
Name: mips_cpu_reg_writeback

Overview:
- Write-side initiator for the CPU register file; the single owner of its write port (write_enable, write_reg, write_data).
- Accepts result requests from two producers: ALU/link results and delayed load results.
- Holds requests in a small in-order pending buffer and issues at most one register-file write per cycle.
- Provides a forwarding lookup for writes that have not yet committed, plus a stall signal toward the pipeline.

Parameters:
- DEPTH, 4, number of pending-write entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  load result request
- ld_dest  in  5  load destination register
- ld_data  in  32  load result
- alu_valid  in  1  ALU/link result request
- alu_dest  in  5  ALU destination register
- alu_data  in  32  ALU result
- fwd_reg  in  5  register to look up among pending writes
- fwd_hit  out  1  fwd_reg has an uncommitted pending write
- fwd_data  out  32  data of the youngest matching pending write
- stall  out  1  producers must not issue new requests
- overflow  out  1  sticky error flag: a request was dropped because the buffer was full
- pending_count  out  $clog2(DEPTH)+1  number of occupied entries
- write_enable  out  1  register-file write strobe
- write_reg  out  5  register-file write address
- write_data  out  32  register-file write data

Behaviour:
- Reset: the clock and reset are one clock, synchronous active-high reset. On reset the buffer empties, all pending writes are discarded (including reset mid-operation), overflow is 0, pending_count is 0, and write_enable is 0.
- Buffer: circular FIFO of {reg[4:0], data[31:0]} with head/tail pointers and a count; pointers wrap modulo DEPTH.
- Requests with dest == 0 are discarded: never enqueued, never counted, never written.
- Enqueue happens at the posedge where valid is sampled.
- When ld and alu requests arrive in the same cycle, ld is enqueued first because it belongs to the older instruction, then alu; both land in the same cycle.
- Write port is combinational from the head entry:
  - write_enable = (count != 0); write_reg/write_data = head fields.
  - Head pops at the same posedge the register file commits.
- Minimum latency: request sampled at edge k, write_enable high during cycle k+1, register updated at edge k+1. There is no bypass directly to the write port.
- A push and a pop in the same cycle are both honoured; count changes by pushes minus the pop.
- stall = (DEPTH - count) < 2, combinational; this guarantees room for a dual push.
- Overflow: any request (nonzero dest) arriving when no free slot remains after that cycle's pop is dropped and sets overflow. overflow stays set until reset. For a dual push with only one slot free, ld is kept and alu is dropped.
- Forwarding:
  - fwd_hit = 1 when fwd_reg != 0 and any occupied entry has reg == fwd_reg.
  - fwd_data = data of the youngest such entry (closest to tail).
  - When there is no hit, fwd_data = 0.
  - Lookup covers buffered entries only, not same-cycle requests.
- Commit order equals enqueue order, so the final register value is always the youngest write.

Optional Feature:
- Macro: MIPS_CPU_WB_TRACE_EN.
- Defined: on each posedge with write_enable high and reset low, $display the destination register number and write_data in decimal; on each overflow drop, $display an error line naming the source (ld/alu) and dest.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - REG_ADDR_W = 5, DATA_W = 32
  - typedef wb_entry_t (struct: reg, data)
  - constant REG_ZERO = 5'd0
- Natural sub-module: mips_cpu_wb_fifo, a parameterised circular buffer with push x2/pop, count, and an exposed entry array for the forward search. The top level holds the arbitration, zero-dest filtering, forward priority search and overflow flag.

Test Plan:
- Single write: alu_valid=1, alu_dest=8, alu_data=0x1234 for 1 cycle -> next cycle write_enable=1, write_reg=8, write_data=0x1234; after that pending_count=0.
- Dual push order: ld(dest=3, 0xAAAA) and alu(dest=3, 0xBBBB) in the same cycle -> writes issue ld then alu on consecutive cycles; reg 3 ends at 0xBBBB; fwd_reg=3 in between gives fwd_hit=1, fwd_data=0xBBBB.
- Zero register: alu_dest=0, alu_data=0xFFFF -> no write_enable, pending_count stays 0, fwd_reg=0 gives fwd_hit=0.
- Fill/stall: DEPTH=4, dual pushes for 2 cycles -> stall rises once count reaches 3; an extra dual push at count=4 with one pop -> ld accepted, alu dropped, overflow=1 and stays 1.
- Wrap-around: 10 sequential single pushes to regs 1..10, data = 100+i -> all 10 writes appear in order with correct data; pointers wrap without loss.
- Reset mid-operation: 3 entries pending, assert reset for 1 cycle -> write_enable=0 and pending_count=0 the next cycle, no pending write commits, overflow=0.
